// File: rtl/nibble_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
package nibble_adder_pkg;

    // Sequencer states: wait for operands, step nibbles, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the shared adder slice.
    localparam int NIB_W = 4;

    // Number of nibble steps needed to cover an operand.
    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4_slice.sv
// Single 4-bit adder slice with carry in/out, shared by every nibble step.
module add4_slice
    import nibble_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] sum_w;

    // Zero-extend so the carry out lands in the top bit.
    always_comb begin
        sum_w = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
    end

    assign s    = sum_w[NIB_W-1:0];
    assign cout = sum_w[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder sequencer: adds two WIDTH-bit operands through one
// shared 4-bit slice, LSB nibble first, carry chained through a register.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN,
// which adds a 'sub' input latched alongside the operands.
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    // Reject widths the nibble stepping cannot cover exactly.
    generate
        if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t                      state_q, state_d;
    logic [NIB-1:0][NIB_W-1:0]   a_q, b_q, s_q;
    logic [IDX_W-1:0]            idx_q;
    logic                        carry_q;
    logic                        cout_q;

    logic                        accept;
    logic                        step;
    logic                        last_step;
    logic [WIDTH-1:0]            b_load;
    logic                        carry_load;
    logic [NIB_W-1:0]            a_nib, b_nib, sum_nib;
    logic                        slice_cout;

    assign accept    = in_valid && (state_q == IDLE);
    assign step      = (state_q == RUN);
    assign last_step = step && (idx_q == LAST_IDX);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    // Subtraction as A + ~B + 1: invert B on load and seed the carry.
    assign b_load     = sub ? ~B : B;
    assign carry_load = sub;
`else
    assign b_load     = B;
    assign carry_load = 1'b0;
`endif

    // Nibble select feeding the shared slice.
    assign a_nib = a_q[idx_q];
    assign b_nib = b_q[idx_q];

    add4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (sum_nib),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: accept, step through nibbles, hold until drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)    state_d = RUN;
            RUN:  if (last_step) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Operand capture and per-nibble result/carry update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= b_load;
            carry_q <= carry_load;
            idx_q   <= '0;
        end else if (step) begin
            s_q[idx_q] <= sum_nib;
            carry_q    <= slice_cout;
            idx_q      <= last_step ? '0 : idx_q + IDX_W'(1);
            if (last_step) cout_q <= slice_cout;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A, B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_s;
        logic             exp_c;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, handshake, then wait for out_valid and check latency.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s_bit, input string name);
        int n;
        A = a; B = b; in_valid = 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub = s_bit;
`endif
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        chk({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk({name, " busy"}, {31'b0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk({name, " latency"}, n, NIB);
    endtask

    task automatic finish_op(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, " back to idle"}, {30'b0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic             s_bit;
        logic [WIDTH:0]   exp_q[$];
        logic [WIDTH:0]   exp_v;
        bit               will_acc, will_done;
        int               n_acc, n_done, done_edge, edge_n;

        s_bit = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        vecs[0] = '{16'h0003, 16'h0004, 16'h0007, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 16'h0100, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
        vecs[3] = '{16'h1234, 16'h1111, 16'h2345, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0};

        repeat (3) tick();
        chk("reset in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset busy",      {31'b0, busy},      32'd0);
        chk("reset S",         {16'b0, S},         32'd0);
        chk("reset Cout",      {31'b0, Cout},      32'd0);
        rst_n = 1'b1;
        tick();

        // Table of directed sums.
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, s_bit, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d S", i),    {16'b0, S},    {16'b0, vecs[i].exp_s});
            chk($sformatf("vec%0d Cout", i), {31'b0, Cout}, {31'b0, vecs[i].exp_c});
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure: result holds, new in_valid is ignored.
        start_op(16'hFFFF, 16'hFFFF, s_bit, "bp");
        A = 16'h0001; B = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp hold", {14'b0, out_valid, in_ready, Cout, S}, {14'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE});
        end
        in_valid = 1'b0;
        finish_op("bp");
        chk("bp S after release", {16'b0, S}, 32'h0000FFFE);

        // Reset in the third RUN cycle aborts the operation.
        A = 16'h1234; B = 16'h1111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort still busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort state", {29'b0, in_ready, out_valid, busy}, 32'd4);
        chk("abort S",     {16'b0, S},    32'd0);
        chk("abort Cout",  {31'b0, Cout}, 32'd0);
        rst_n = 1'b1;
        tick();
        start_op(16'h0005, 16'h0005, s_bit, "post abort");
        chk("post abort S", {15'b0, Cout, S}, 32'h0000000A);
        finish_op("post abort");

        // Back-to-back random ops with in_valid held and out_ready high.
        n_acc = 0; n_done = 0; done_edge = 0; edge_n = 0;
        A = WIDTH'($urandom); B = WIDTH'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        while (n_done < 200 && edge_n < 5000) begin
            will_acc  = in_valid && in_ready;
            will_done = out_valid && out_ready;
            if (will_done) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                chk("b2b sum", {15'b0, Cout, S}, {15'b0, exp_v});
            end
            tick();
            edge_n++;
            if (will_done) begin done_edge = edge_n; n_done++; end
            if (will_acc) begin
                exp_q.push_back({1'b0, A} + {1'b0, B});
                if (n_acc > 0) chk("b2b accept gap", edge_n, done_edge + 1);
                n_acc++;
                A = WIDTH'($urandom); B = WIDTH'($urandom);
                if (n_acc >= 200) in_valid = 1'b0;
            end
        end
        chk("b2b completed", n_done, 200);
        in_valid = 1'b0; out_ready = 1'b0;
        tick();

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        start_op(16'h0005, 16'h0007, 1'b1, "sub1");
        chk("sub1 result", {15'b0, Cout, S}, 32'h0000FFFE);
        finish_op("sub1");
        start_op(16'h0009, 16'h0002, 1'b1, "sub2");
        chk("sub2 result", {15'b0, Cout, S}, 32'h00010007);
        finish_op("sub2");
        sub = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
